// File: rtl/fp_addsub_pipe.sv
// Three-stage floating-point add/sub/int-convert unit with valid/ready handshake.
// Stages: unpack/align -> signed-magnitude add (and FLOOR) -> normalise/round.
module fp_addsub_pipe #(
    parameter int EW   = 8,
    parameter int MW   = 23,
    parameter int TAGW = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        op,
    input  logic [EW+MW:0]    x,
    input  logic [EW+MW:0]    y,
    input  logic [TAGW-1:0]   tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [EW+MW:0]    z,
    output logic [TAGW-1:0]   out_tag,
    output logic              ovf,
    output logic              inx
);
    localparam int W    = 1 + EW + MW;
    localparam int FW   = MW + 4;
    localparam int SW   = MW + 5;
    localparam int VW   = W + MW;
    localparam int LZW  = $clog2(W) + 1;
    localparam int EXW  = EW + LZW + 2;
    localparam int BIAS = 2**(EW-1) - 1;
    localparam logic signed [EXW-1:0] EMAX  = EXW'(2**EW - 1);
    localparam logic signed [EXW-1:0] IMAXE = EXW'(W - 1);

    typedef enum logic [1:0] {OP_ADD = 2'd0, OP_SUB = 2'd1, OP_FLT = 2'd2, OP_FLOOR = 2'd3} op_e;

    logic en;
    op_e  opi;
    assign en       = ~out_valid | out_ready;
    assign in_ready = en;
    assign opi      = op_e'(op);

    // stage registers
    logic                  v1, sa1, sb1;
    op_e                   op1;
    logic signed [EXW-1:0] e1;
    logic [FW-1:0]         fa1, fb1;
    logic [TAGW-1:0]       tag1;
    logic                  v2, sg2, io2, ii2;
    op_e                   op2;
    logic signed [EXW-1:0] e2;
    logic [SW-1:0]         sum2;
    logic [W-1:0]          iz2;
    logic [TAGW-1:0]       tag2;

    // stage 1: unpack / align
    logic [EW-1:0]         exa, eya, eb, es, d;
    logic [MW:0]           mxa, mya, mb, ms;
    logic                  sya, n_sa, n_sb;
    logic [W-1:0]          mag, norm;
    logic [LZW-1:0]        lz1;
    logic [2*FW-1:0]       wide;
    logic signed [EXW-1:0] n_e;
    logic [FW-1:0]         n_fa, n_fb;

    always_comb begin
        exa = x[W-2:MW];
        eya = y[W-2:MW];
        mxa = (exa == '0) ? '0 : {1'b1, x[MW-1:0]};
        mya = (eya == '0) ? '0 : {1'b1, y[MW-1:0]};
        sya = y[W-1] ^ (opi == OP_SUB);
        mag = x[W-1] ? -x : x;
        lz1 = '0;
        for (int unsigned i = 0; i < W; i++)
            if (mag[i]) lz1 = LZW'(W - 1 - i);
        norm = mag << lz1;
        if (exa >= eya) begin
            eb = exa; es = eya; mb = mxa; ms = mya; n_sa = x[W-1]; n_sb = sya;
        end else begin
            eb = eya; es = exa; mb = mya; ms = mxa; n_sa = sya; n_sb = x[W-1];
        end
        d    = eb - es;
        wide = {ms, 3'b000, {FW{1'b0}}} >> d;
        n_fa = {mb, 3'b000};
        // beyond the field width only the sticky bit can survive
        n_fb = (int'(d) >= FW) ? {{(FW-1){1'b0}}, |ms}
                               : {wide[2*FW-1:FW+1], wide[FW] | (|wide[FW-1:0])};
        n_e  = EXW'(eb);
        case (opi)
            OP_FLT: begin
                n_sa = x[W-1];
                n_sb = x[W-1];
                n_fa = {norm[W-1 -: MW+3], |norm[W-MW-4:0]};
                n_fb = '0;
                n_e  = EXW'(BIAS + W - 1) - EXW'(lz1);
            end
            OP_FLOOR: begin
                n_sa = x[W-1];
                n_fa = {mxa, 3'b000};
                n_fb = '0;
                n_e  = EXW'(exa) - EXW'(BIAS);
            end
            default: ;
        endcase
    end

    // stage 2: magnitude add/subtract, FLOOR integer conversion
    logic [SW-1:0] sum_n;
    logic          sg_n, io_n, ii_n, fr;
    logic [MW:0]   m2;
    logic [VW-1:0] v2w;
    logic [W-1:0]  ip, iz_n;

    always_comb begin
        if (sa1 == sb1) begin
            sum_n = {1'b0, fa1} + {1'b0, fb1};
            sg_n  = sa1;
        end else if (fa1 >= fb1) begin
            sum_n = {1'b0, fa1 - fb1};
            sg_n  = sa1;
        end else begin
            sum_n = {1'b0, fb1 - fa1};
            sg_n  = sb1;
        end
        if (sum_n == '0) sg_n = 1'b0;
        m2   = fa1[FW-1:3];
        v2w  = VW'(m2) << e1[LZW-1:0];
        ip   = v2w[VW-1:MW];
        fr   = |v2w[MW-1:0];
        iz_n = '0;
        io_n = 1'b0;
        ii_n = 1'b0;
        if (fa1 != '0) begin
            if (e1[EXW-1]) begin
                iz_n = sa1 ? '1 : '0;
                ii_n = 1'b1;
            end else if (e1 >= IMAXE) begin
                iz_n = sa1 ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
                io_n = 1'b1;
            end else begin
                iz_n = sa1 ? -ip - W'(fr) : ip;
                ii_n = fr;
            end
        end
    end

    // stage 3: normalise, round half to even, range check
    logic [FW-1:0]         f3;
    logic [LZW-1:0]        lz3;
    logic signed [EXW-1:0] e3;
    logic [MW+1:0]         mr;
    logic [MW-1:0]         fr3;
    logic                  rb, ix3, ovn, ixn;
    logic [W-1:0]          zn;

    always_comb begin
        lz3 = '0;
        for (int unsigned i = 0; i < FW; i++)
            if (sum2[i]) lz3 = LZW'(FW - 1 - i);
        if (sum2[SW-1]) begin
            f3 = {sum2[SW-1:2], sum2[1] | sum2[0]};
            e3 = e2 + EXW'(1);
        end else begin
            f3 = sum2[FW-1:0] << lz3;
            e3 = e2 - EXW'(lz3);
        end
        rb  = f3[2] & (f3[1] | f3[0] | f3[3]);
        ix3 = |f3[2:0];
        mr  = {1'b0, f3[FW-1:3]} + (MW+2)'(rb);
        if (mr[MW+1]) begin
            fr3 = mr[MW:1];
            e3  = e3 + EXW'(1);
        end else begin
            fr3 = mr[MW-1:0];
        end
        zn  = '0;
        ovn = 1'b0;
        ixn = 1'b0;
        if (op2 == OP_FLOOR) begin
            zn  = iz2;
            ovn = io2;
            ixn = ii2;
        end else if (sum2 != '0) begin
            if (e3[EXW-1] || e3 == '0) begin
                ixn = 1'b1;
            end else if (e3 >= EMAX) begin
                zn  = {sg2, {(EW-1){1'b1}}, 1'b0, {MW{1'b1}}};
                ovn = 1'b1;
                ixn = ix3;
            end else begin
                zn  = {sg2, e3[EW-1:0], fr3};
                ixn = ix3;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v1        <= 1'b0;
            v2        <= 1'b0;
            out_valid <= 1'b0;
            z         <= '0;
            out_tag   <= '0;
            ovf       <= 1'b0;
            inx       <= 1'b0;
        end else if (en) begin
            v1        <= in_valid;
            op1       <= opi;
            sa1       <= n_sa;
            sb1       <= n_sb;
            e1        <= n_e;
            fa1       <= n_fa;
            fb1       <= n_fb;
            tag1      <= tag;
            v2        <= v1;
            op2       <= op1;
            sg2       <= sg_n;
            e2        <= e1;
            sum2      <= sum_n;
            iz2       <= iz_n;
            io2       <= io_n;
            ii2       <= ii_n;
            tag2      <= tag1;
            out_valid <= v2;
            if (v2) begin
                z       <= zn;
                out_tag <= tag2;
                ovf     <= ovn;
                inx     <= ixn;
            end
        end
    end
endmodule

// File: tb/tb_fp_addsub_pipe.sv
// Directed-vector bench for fp_addsub_pipe (single precision defaults):
// table of hand-computed results plus stall-stream and mid-flight reset sequences.
module tb_fp_addsub_pipe;
    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, out_valid, out_ready, ovf, inx;
    logic [1:0]  op;
    logic [31:0] x, y, z;
    logic [3:0]  tag, out_tag;
    int tests = 0;
    int fails = 0;

    typedef struct {
        string       name;
        logic [1:0]  op;
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] z;
        logic        ovf;
        logic        inx;
    } vec_t;
    vec_t vt[$];

    always #5 clk = ~clk;

    fp_addsub_pipe #(.EW(8), .MW(23), .TAGW(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .x(x), .y(y), .tag(tag),
        .out_valid(out_valid), .out_ready(out_ready), .z(z),
        .out_tag(out_tag), .ovf(ovf), .inx(inx)
    );

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic add(input string nm, input logic [1:0] o, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] zz, input logic ov, input logic ix);
        vec_t v;
        v.name = nm; v.op = o; v.x = a; v.y = b; v.z = zz; v.ovf = ov; v.inx = ix;
        vt.push_back(v);
    endtask

    task automatic drive(input vec_t v, input logic [3:0] t);
        in_valid = 1'b1; op = v.op; x = v.x; y = v.y; tag = t;
    endtask

    // single op into an empty pipe; checks latency, result, flags, tag
    task automatic run_one(input vec_t v, input logic [3:0] t);
        int edges;
        drive(v, t);
        @(posedge clk); #1;
        in_valid = 1'b0;
        edges = 1;
        while (!out_valid && edges < 10) begin
            @(posedge clk); #1;
            edges++;
        end
        check({v.name, " latency"}, 32'(edges), 32'd3);
        check({v.name, " z"}, z, v.z);
        check({v.name, " tag"}, 32'(out_tag), 32'(t));
        check({v.name, " ovf"}, 32'(ovf), 32'(v.ovf));
        check({v.name, " inx"}, 32'(inx), 32'(v.inx));
        @(posedge clk); #1;
    endtask

    task automatic stream_test();
        int   sent = 0;
        int   got = 0;
        int   stall = 0;
        logic acc;
        for (int cyc = 0; cyc < 80 && got < 6; cyc++) begin
            out_ready = (cyc < 4 || cyc >= 12);
            if (sent < 6) drive(vt[sent], 4'(sent + 8));
            else in_valid = 1'b0;
            #1;
            if (out_valid && !out_ready) begin
                check("stall in_ready", 32'(in_ready), 32'd0);
                check("stall z held", z, vt[got].z);
                stall++;
            end
            if (out_valid && out_ready) begin
                check("stream z", z, vt[got].z);
                check("stream tag", 32'(out_tag), 32'(got + 8));
                got++;
            end
            acc = in_valid && in_ready;
            @(posedge clk); #1;
            if (acc) sent++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("stream results", 32'(got), 32'd6);
        check("stream stall cycles", 32'(stall), 32'd8);
        check("stream drained", 32'(out_valid), 32'd0);
    endtask

    task automatic reset_test();
        for (int k = 0; k < 3; k++) begin
            drive(vt[k], 4'(k + 4));
            if (k == 2) rst = 1'b1;
            @(posedge clk); #1;
        end
        rst = 1'b0;
        in_valid = 1'b0;
        check("flush out_valid", 32'(out_valid), 32'd0);
        check("flush z", z, 32'd0);
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            check("flush no stale", 32'(out_valid), 32'd0);
        end
        run_one(vt[1], 4'hC);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; op = 2'd0; x = '0; y = '0; tag = '0; out_ready = 1'b1;

        add("add 1+1",        2'd0, 32'h3F800000, 32'h3F800000, 32'h40000000, 1'b0, 1'b0);
        add("sub 1-1",        2'd1, 32'h3F800000, 32'h3F800000, 32'h00000000, 1'b0, 1'b0);
        add("add tie even",   2'd0, 32'h3F800000, 32'h33800000, 32'h3F800000, 1'b0, 1'b1);
        add("add above tie",  2'd0, 32'h3F800000, 32'h33800001, 32'h3F800001, 1'b0, 1'b1);
        add("flt 7",          2'd2, 32'h00000007, 32'h12345678, 32'h40E00000, 1'b0, 1'b0);
        add("flt -1",         2'd2, 32'hFFFFFFFF, 32'h12345678, 32'hBF800000, 1'b0, 1'b0);
        add("floor -1.5",     2'd3, 32'hBFC00000, 32'h12345678, 32'hFFFFFFFE, 1'b0, 1'b1);
        add("floor 2^31",     2'd3, 32'h4F000000, 32'h12345678, 32'h7FFFFFFF, 1'b1, 1'b0);
        add("add max ovf",    2'd0, 32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F7FFFFF, 1'b1, 1'b0);
        add("sub underflow",  2'd1, 32'h00800000, 32'h00800001, 32'h00000000, 1'b0, 1'b1);
        add("add 0+3",        2'd0, 32'h00000000, 32'h40400000, 32'h40400000, 1'b0, 1'b0);
        add("sub 0-3",        2'd1, 32'h00000000, 32'h40400000, 32'hC0400000, 1'b0, 1'b0);
        add("add 3+0",        2'd0, 32'h40400000, 32'h00000000, 32'h40400000, 1'b0, 1'b0);
        add("flt 0",          2'd2, 32'h00000000, 32'h12345678, 32'h00000000, 1'b0, 1'b0);
        add("floor 0.5",      2'd3, 32'h3F000000, 32'h12345678, 32'h00000000, 1'b0, 1'b1);
        add("floor -0.5",     2'd3, 32'hBF000000, 32'h12345678, 32'hFFFFFFFF, 1'b0, 1'b1);
        add("floor 2.5",      2'd3, 32'h40200000, 32'h12345678, 32'h00000002, 1'b0, 1'b1);
        add("floor -3",       2'd3, 32'hC0400000, 32'h12345678, 32'hFFFFFFFD, 1'b0, 1'b0);
        add("floor -2^31",    2'd3, 32'hCF000000, 32'h12345678, 32'h80000000, 1'b1, 1'b0);
        add("add 2+(-1)",     2'd0, 32'h40000000, 32'hBF800000, 32'h3F800000, 1'b0, 1'b0);
        add("sub 1-2",        2'd1, 32'h3F800000, 32'h40000000, 32'hBF800000, 1'b0, 1'b0);
        add("sub cancel",     2'd1, 32'h3F800001, 32'h3F800000, 32'h34000000, 1'b0, 1'b0);
        add("flt -2^31",      2'd2, 32'h80000000, 32'h12345678, 32'hCF000000, 1'b0, 1'b0);
        add("flt 2^24+1",     2'd2, 32'h01000001, 32'h12345678, 32'h4B800000, 1'b0, 1'b1);
        add("add round carry",2'd0, 32'h3F7FFFFF, 32'h33000000, 32'h3F800000, 1'b0, 1'b1);

        repeat (2) @(posedge clk);
        #1;
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset z", z, 32'd0);
        check("reset out_tag", 32'(out_tag), 32'd0);
        check("reset ovf", 32'(ovf), 32'd0);
        check("reset inx", 32'(inx), 32'd0);
        check("reset in_ready", 32'(in_ready), 32'd1);
        rst = 1'b0;

        for (int i = 0; i < vt.size(); i++) run_one(vt[i], 4'(i));

        stream_test();
        reset_test();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
